// File: rtl/instrumented_adder_pkg.sv
// Shared types and default widths for the instrumented-adder ring-oscillator counter.
package instrumented_adder_pkg;

    localparam int unsigned COUNT_W_DEF     = 32;
    localparam int unsigned GATE_W_DEF      = 32;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/instrumented_adder_ro_counter_ro_sync_edge.sv
// Synchronises the asynchronous ring-oscillator level and produces single-cycle
// rise/fall pulses against a history flop that is only advanced while tracking.
module ro_sync_edge
    import instrumented_adder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ro,
    input  logic load_hist,
    input  logic track,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Synchroniser chain and edge history; history is seeded on load so the first
    // tracked cycle never reports a stale edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro};
            if (load_hist || track) begin
                hist_q <= level;
            end
        end
    end

    assign rise_c = track &  level & ~hist_q;
    assign fall_c = track & ~level &  hist_q;

endmodule

// File: rtl/instrumented_adder_ro_counter.sv
// Gated edge counter for the adder ring oscillator: counts synchronised ro_in edges
// over N clocks. Define RO_DUAL_EDGE_EN to count both rising and falling edges.
module instrumented_adder_ro_counter
    import instrumented_adder_pkg::*;
#(
    parameter int unsigned COUNT_W     = COUNT_W_DEF,
    parameter int unsigned GATE_W      = GATE_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               ro_in,
    input  logic               start,
    input  logic [GATE_W-1:0]  gate_cycles,
    output logic               busy,
    output logic [COUNT_W-1:0] count_out,
    output logic               count_valid,
    output logic               overflow
);

`ifdef RO_DUAL_EDGE_EN
    localparam logic DUAL_EDGE = 1'b1;
`else
    localparam logic DUAL_EDGE = 1'b0;
`endif

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    state_e              state_q;
    state_e              state_next;
    logic [GATE_W-1:0]   n_q;
    logic [GATE_W-1:0]   n_next;
    logic [GATE_W-1:0]   gate_q;
    logic [GATE_W-1:0]   gate_next;
    logic [COUNT_W-1:0]  count_next;
    logic                valid_next;
    logic                ovf_next;
    logic                busy_next;
    logic                load_hist_c;
    logic                track_c;
    logic                rise_c;
    logic                fall_c;
    logic                edge_c;

    ro_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .ro        (ro_in),
        .load_hist (load_hist_c),
        .track     (track_c),
        .rise_c    (rise_c),
        .fall_c    (fall_c)
    );

    assign edge_c = rise_c | (DUAL_EDGE & fall_c);

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            gate_q      <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_next;
            n_q         <= n_next;
            gate_q      <= gate_next;
            count_out   <= count_next;
            count_valid <= valid_next;
            overflow    <= ovf_next;
            busy        <= busy_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next  = state_q;
        n_next      = n_q;
        gate_next   = gate_q;
        count_next  = count_out;
        valid_next  = count_valid;
        ovf_next    = overflow;
        load_hist_c = 1'b0;
        track_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_next     = gate_cycles;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    valid_next = (gate_cycles == '0);
                    if (gate_cycles != '0) begin
                        state_next = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                load_hist_c = 1'b1;
                gate_next   = n_q;
                state_next  = ST_MEASURE;
            end
            ST_MEASURE: begin
                track_c   = 1'b1;
                gate_next = gate_q - GATE_W'(1);
                if (edge_c) begin
                    if (count_out == COUNT_MAX) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = count_out + COUNT_W'(1);
                    end
                end
                // gate_q can only be 0 here if the window was corrupted; exit anyway.
                if (gate_q <= GATE_W'(1)) begin
                    state_next = ST_IDLE;
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_instrumented_adder_ro_counter.sv
// Directed bench for instrumented_adder_ro_counter: a default-width instance and a
// 4-bit-counter instance for saturation. Expected counts scale with RO_DUAL_EDGE_EN.
module tb_instrumented_adder_ro_counter;

`ifdef RO_DUAL_EDGE_EN
    localparam int unsigned EDGE_MUL = 2;
`else
    localparam int unsigned EDGE_MUL = 1;
`endif

    logic        clk;
    logic        rst;
    logic        ro;
    logic        start;
    logic [31:0] gate;
    logic        busy;
    logic [31:0] count;
    logic        valid;
    logic        ovf;

    logic        ro_s;
    logic        start_s;
    logic [31:0] gate_s;
    logic        busy_s;
    logic [3:0]  count_s;
    logic        valid_s;
    logic        ovf_s;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned busy_cnt;

    instrumented_adder_ro_counter dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .ro_in       (ro),
        .start       (start),
        .gate_cycles (gate),
        .busy        (busy),
        .count_out   (count),
        .count_valid (valid),
        .overflow    (ovf)
    );

    instrumented_adder_ro_counter #(
        .COUNT_W (4)
    ) dut_sat (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .ro_in       (ro_s),
        .start       (start_s),
        .gate_cycles (gate_s),
        .busy        (busy_s),
        .count_out   (count_s),
        .count_valid (valid_s),
        .overflow    (ovf_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running oscillators, offset from the clock edges: period 8 and 2 clocks.
    initial begin
        ro = 1'b0;
        #3;
        forever #40 ro = ~ro;
    end

    initial begin
        ro_s = 1'b0;
        #3;
        forever #10 ro_s = ~ro_s;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle_main(inout int unsigned cnt);
        int unsigned guard;
        guard = 0;
        while (busy === 1'b1 && guard < 1000) begin
            cnt++;
            guard++;
            step();
        end
    endtask

    task automatic wait_idle_sat(inout int unsigned cnt);
        int unsigned guard;
        guard = 0;
        while (busy_s === 1'b1 && guard < 1000) begin
            cnt++;
            guard++;
            step();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        start   = 1'b0;
        gate    = '0;
        start_s = 1'b0;
        gate_s  = '0;

        // Reset held for two cycles.
        step();
        step();
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        check("rst_count", count,      32'd0);
        check("rst_sat_count", 32'(count_s), 32'd0);
        rst = 1'b0;
        repeat (5) step();

        // Period-8 oscillator, N=80.
        start = 1'b1;
        gate  = 32'd80;
        step();
        start = 1'b0;
        check("p8_arm_valid", 32'(valid), 32'd0);
        check("p8_arm_count", count,      32'd0);
        busy_cnt = 0;
        wait_idle_main(busy_cnt);
        check("p8_busy_cycles", busy_cnt,    32'd81);
        check("p8_valid",       32'(valid),  32'd1);
        check("p8_count",       count,       32'(10 * EDGE_MUL));
        check("p8_ovf",         32'(ovf),    32'd0);
        repeat (3) step();
        check("p8_hold_count",  count,       32'(10 * EDGE_MUL));

        // Zero gate while a result is valid: result cleared, valid next cycle, no busy.
        start = 1'b1;
        gate  = 32'd0;
        step();
        start = 1'b0;
        check("zero_valid", 32'(valid), 32'd1);
        check("zero_count", count,      32'd0);
        check("zero_busy",  32'(busy),  32'd0);
        step();
        check("zero_busy_later", 32'(busy), 32'd0);

        // Restart from valid, then a second start mid-MEASURE must be ignored.
        start = 1'b1;
        gate  = 32'd40;
        step();
        start = 1'b0;
        check("ign_valid_drop", 32'(valid), 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_cnt++;
            step();
        end
        start = 1'b1;
        gate  = 32'd5;
        if (busy === 1'b1) busy_cnt++;
        step();
        start = 1'b0;
        wait_idle_main(busy_cnt);
        check("ign_busy_cycles", busy_cnt,   32'd41);
        check("ign_count",       count,      32'(5 * EDGE_MUL));
        check("ign_valid",       32'(valid), 32'd1);

        // Reset mid-MEASURE aborts; next start measures normally.
        start = 1'b1;
        gate  = 32'd80;
        step();
        start = 1'b0;
        repeat (30) step();
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_ovf",   32'(ovf),   32'd0);
        check("abort_count", count,      32'd0);
        repeat (4) step();
        start = 1'b1;
        gate  = 32'd16;
        step();
        start = 1'b0;
        busy_cnt = 0;
        wait_idle_main(busy_cnt);
        check("post_abort_busy_cycles", busy_cnt,   32'd17);
        check("post_abort_count",       count,      32'(2 * EDGE_MUL));
        check("post_abort_valid",       32'(valid), 32'd1);

        // Start coincident with reset is ignored.
        rst   = 1'b1;
        start = 1'b1;
        gate  = 32'd8;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy",  32'(busy),  32'd0);
        check("rst_start_valid", 32'(valid), 32'd0);
        step();
        check("rst_start_busy2", 32'(busy),  32'd0);

        // Saturation on the 4-bit instance: period-2 oscillator, N=40.
        start_s = 1'b1;
        gate_s  = 32'd40;
        step();
        start_s = 1'b0;
        busy_cnt = 0;
        wait_idle_sat(busy_cnt);
        check("sat_busy_cycles", busy_cnt,      32'd41);
        check("sat_count",       32'(count_s),  32'd15);
        check("sat_ovf",         32'(ovf_s),    32'd1);
        check("sat_valid",       32'(valid_s),  32'd1);
        step();
        check("sat_ovf_hold",    32'(ovf_s),    32'd1);

        // A new start clears overflow.
        start_s = 1'b1;
        gate_s  = 32'd0;
        step();
        start_s = 1'b0;
        check("sat_clear_ovf",   32'(ovf_s),   32'd0);
        check("sat_clear_count", 32'(count_s), 32'd0);
        check("sat_clear_valid", 32'(valid_s), 32'd1);

        // Short window on the fast oscillator: exactly one rise per two transitions.
        start_s = 1'b1;
        gate_s  = 32'd2;
        step();
        start_s = 1'b0;
        busy_cnt = 0;
        wait_idle_sat(busy_cnt);
        check("short_busy_cycles", busy_cnt,     32'd3);
        check("short_count",       32'(count_s), 32'(EDGE_MUL));
        check("short_ovf",         32'(ovf_s),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
